// File: rtl/flush_scheduler.sv
// Write-back flush sequencer: walks the dirty bitmap lowest-sector-first, writes each
// sector with bounded retries and clears its tracker bit once storage confirms it.
module flush_scheduler #(
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] dirty_sectors,
  input  logic        all_clean,
  input  logic        flush_start,
  output logic        wr_req,
  output logic [5:0]  wr_saddr,
  input  logic        wr_ack,
  input  logic        wr_done,
  input  logic        wr_ok,
  output logic        clean_en,
  output logic [5:0]  clean_saddr,
  output logic        clean_d,
  output logic        busy,
  output logic        flush_done,
  output logic        flush_error,
  output logic [6:0]  flushed_count
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISSUE,
    WAIT,
    CLEAR,
    DONE,
    ERROR
  } state_t;

  state_t     state;
  logic [3:0] retry_cnt;
  logic [3:0] retry_next;
  logic [5:0] lowest_dirty;

  // Priority encoder: the last assignment in the descending loop wins, giving the lowest set bit.
  always_comb begin
    lowest_dirty = '0;
    for (int i = 63; i >= 0; i--) begin
      if (dirty_sectors[i]) lowest_dirty = 6'(i);
    end
  end

  assign retry_next = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
  assign clean_d    = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      retry_cnt     <= '0;
      wr_req        <= 1'b0;
      wr_saddr      <= '0;
      clean_en      <= 1'b0;
      clean_saddr   <= '0;
      busy          <= 1'b0;
      flush_done    <= 1'b0;
      flush_error   <= 1'b0;
      flushed_count <= '0;
    end else begin
      flush_done <= 1'b0;
      clean_en   <= 1'b0;
      case (state)
        IDLE, ERROR: begin
          if (flush_start) begin
            flushed_count <= '0;
            retry_cnt     <= '0;
            flush_error   <= 1'b0;
            busy          <= 1'b1;
            state         <= SCAN;
          end
        end
        SCAN: begin
          if (all_clean) begin
            flush_done <= 1'b1;
            state      <= DONE;
          end else begin
            wr_saddr <= lowest_dirty;
            wr_req   <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (wr_done) begin
            if (wr_ok) begin
              clean_en    <= 1'b1;
              clean_saddr <= wr_saddr;
              state       <= CLEAR;
            end else begin
              retry_cnt <= retry_next;
              if ({28'd0, retry_next} < MAX_RETRY) begin
                wr_req <= 1'b1;
                state  <= ISSUE;
              end else begin
                busy        <= 1'b0;
                flush_error <= 1'b1;
                state       <= ERROR;
              end
            end
          end
        end
        CLEAR: begin
          flushed_count <= flushed_count + 7'd1;
          retry_cnt     <= '0;
          state         <= SCAN;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
